// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS data-memory arbiter: opcodes, FSM encoding
// and the default memory depth.
package mips_mem_pkg;

   localparam logic [5:0] OP_SB = 6'h28;
   localparam logic [5:0] OP_SH = 6'h29;
   localparam logic [5:0] OP_SW = 6'h2B;
   localparam logic [5:0] OP_LW = 6'h23;

   localparam int unsigned DEFAULT_DEPTH = 256;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StAccess = 2'd1,
      StResp   = 2'd2
   } arb_state_e;

   function automatic logic is_store_op(input logic [5:0] op);
      return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
   endfunction

endpackage

// File: rtl/mips_rr_arbiter2.sv
// Two-way round-robin selector; winner=0 picks A, winner=1 picks B.
// last_winner resets to B so A wins the first conflict.
module mips_rr_arbiter2 (
   input  logic clk,
   input  logic reset,
   input  logic req_a,
   input  logic req_b,
   input  logic advance,
   output logic winner
);

   logic last_b_q, last_b_d;

   always_comb begin
      if (req_a && !req_b) begin
         winner = 1'b0;
      end else if (req_b && !req_a) begin
         winner = 1'b1;
      end else begin
         winner = !last_b_q;
      end
      last_b_d = advance ? winner : last_b_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         last_b_q <= 1'b1;
      end else begin
         last_b_q <= last_b_d;
      end
   end

endmodule

// File: rtl/mips_dmem_arbiter.sv
// Shares the single-port data memory between the CPU (A) and debug/loader (B)
// ports with a registered IDLE -> ACCESS -> RESP handshake.
module mips_dmem_arbiter
   import mips_mem_pkg::*;
#(
   parameter int unsigned DEPTH  = DEFAULT_DEPTH,
   parameter int unsigned ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_a,
   input  logic              req_b,
   input  logic              we_a,
   input  logic              we_b,
   input  logic [ADDR_W-1:0] addr_a,
   input  logic [ADDR_W-1:0] addr_b,
   input  logic [31:0]       wdata_a,
   input  logic [31:0]       wdata_b,
   input  logic [5:0]        opcode_a,
   input  logic [5:0]        opcode_b,
   output logic              gnt_a,
   output logic              gnt_b,
   output logic              done_a,
   output logic              done_b,
   output logic              err_a,
   output logic              err_b,
   output logic [31:0]       rdata_a,
   output logic [31:0]       rdata_b,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [5:0]        mem_opcode,
   output logic              mem_write,
   output logic              mem_read,
   input  logic [31:0]       mem_rdata
);

   localparam logic [ADDR_W-1:0] DepthLim = ADDR_W'(DEPTH);

   arb_state_e state_q, state_d;
   logic sel_b_q, sel_b_d, sel_we_q, sel_we_d, sel_err_q, sel_err_d;
   logic gnt_a_q, gnt_a_d, gnt_b_q, gnt_b_d;
   logic done_a_q, done_a_d, done_b_q, done_b_d;
   logic err_a_q, err_a_d, err_b_q, err_b_d;
   logic [31:0] rdata_a_q, rdata_a_d, rdata_b_q, rdata_b_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic [5:0] mem_opcode_q, mem_opcode_d;
   logic mem_write_q, mem_write_d, mem_read_q, mem_read_d;

   logic winner, advance;
   logic req_we, req_bad;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0] req_wdata;
   logic [5:0] req_opcode;

   mips_rr_arbiter2 u_rr (
      .clk     (clk),
      .reset   (reset),
      .req_a   (req_a),
      .req_b   (req_b),
      .advance (advance),
      .winner  (winner)
   );

   always_comb begin
      req_we     = winner ? we_b     : we_a;
      req_addr   = winner ? addr_b   : addr_a;
      req_wdata  = winner ? wdata_b  : wdata_a;
      req_opcode = winner ? opcode_b : opcode_a;
      req_bad    = (req_addr >= DepthLim) || (req_we && !is_store_op(req_opcode));
   end

   always_comb begin
      state_d      = state_q;
      sel_b_d      = sel_b_q;
      sel_we_d     = sel_we_q;
      sel_err_d    = sel_err_q;
      advance      = 1'b0;
      gnt_a_d      = 1'b0;
      gnt_b_d      = 1'b0;
      done_a_d     = 1'b0;
      done_b_d     = 1'b0;
      err_a_d      = 1'b0;
      err_b_d      = 1'b0;
      rdata_a_d    = rdata_a_q;
      rdata_b_d    = rdata_b_q;
      mem_addr_d   = '0;
      mem_wdata_d  = '0;
      mem_opcode_d = '0;
      mem_write_d  = 1'b0;
      mem_read_d   = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (req_a || req_b) begin
               advance   = 1'b1;
               sel_b_d   = winner;
               sel_we_d  = req_we;
               sel_err_d = req_bad;
               gnt_a_d   = !winner;
               gnt_b_d   = winner;
               // Memory bus values are registered here so they appear exactly in ACCESS.
               if (!req_bad) begin
                  mem_addr_d   = req_addr;
                  mem_wdata_d  = req_wdata;
                  mem_opcode_d = req_opcode;
                  mem_write_d  = req_we;
                  mem_read_d   = !req_we;
               end
               state_d = StAccess;
            end
         end
         StAccess: begin
            if (sel_b_q) begin
               done_b_d  = 1'b1;
               err_b_d   = sel_err_q;
               rdata_b_d = (!sel_err_q && !sel_we_q) ? mem_rdata : 32'h0;
            end else begin
               done_a_d  = 1'b1;
               err_a_d   = sel_err_q;
               rdata_a_d = (!sel_err_q && !sel_we_q) ? mem_rdata : 32'h0;
            end
            state_d = StResp;
         end
         StResp: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StIdle;
         sel_b_q      <= 1'b0;
         sel_we_q     <= 1'b0;
         sel_err_q    <= 1'b0;
         gnt_a_q      <= 1'b0;
         gnt_b_q      <= 1'b0;
         done_a_q     <= 1'b0;
         done_b_q     <= 1'b0;
         err_a_q      <= 1'b0;
         err_b_q      <= 1'b0;
         rdata_a_q    <= '0;
         rdata_b_q    <= '0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         mem_opcode_q <= '0;
         mem_write_q  <= 1'b0;
         mem_read_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         sel_b_q      <= sel_b_d;
         sel_we_q     <= sel_we_d;
         sel_err_q    <= sel_err_d;
         gnt_a_q      <= gnt_a_d;
         gnt_b_q      <= gnt_b_d;
         done_a_q     <= done_a_d;
         done_b_q     <= done_b_d;
         err_a_q      <= err_a_d;
         err_b_q      <= err_b_d;
         rdata_a_q    <= rdata_a_d;
         rdata_b_q    <= rdata_b_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         mem_opcode_q <= mem_opcode_d;
         mem_write_q  <= mem_write_d;
         mem_read_q   <= mem_read_d;
      end
   end

   assign gnt_a      = gnt_a_q;
   assign gnt_b      = gnt_b_q;
   assign done_a     = done_a_q;
   assign done_b     = done_b_q;
   assign err_a      = err_a_q;
   assign err_b      = err_b_q;
   assign rdata_a    = rdata_a_q;
   assign rdata_b    = rdata_b_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign mem_opcode = mem_opcode_q;
   assign mem_write  = mem_write_q;
   assign mem_read   = mem_read_q;

endmodule

// File: tb/tb_mips_dmem_arbiter.sv
// Directed bench for mips_dmem_arbiter with a 256-word behavioural memory.
module tb_mips_dmem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_a, req_b, we_a, we_b;
   logic [31:0] addr_a, addr_b, wdata_a, wdata_b;
   logic [5:0]  opcode_a, opcode_b;
   logic        gnt_a, gnt_b, done_a, done_b, err_a, err_b;
   logic [31:0] rdata_a, rdata_b;
   logic [31:0] mem_addr, mem_wdata;
   logic [5:0]  mem_opcode;
   logic        mem_write, mem_read;
   logic [31:0] mem_rdata;

   logic [31:0] mem [256];
   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   mips_dmem_arbiter #(.DEPTH(256), .ADDR_W(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_a      (req_a),
      .req_b      (req_b),
      .we_a       (we_a),
      .we_b       (we_b),
      .addr_a     (addr_a),
      .addr_b     (addr_b),
      .wdata_a    (wdata_a),
      .wdata_b    (wdata_b),
      .opcode_a   (opcode_a),
      .opcode_b   (opcode_b),
      .gnt_a      (gnt_a),
      .gnt_b      (gnt_b),
      .done_a     (done_a),
      .done_b     (done_b),
      .err_a      (err_a),
      .err_b      (err_b),
      .rdata_a    (rdata_a),
      .rdata_b    (rdata_b),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_opcode (mem_opcode),
      .mem_write  (mem_write),
      .mem_read   (mem_read),
      .mem_rdata  (mem_rdata)
   );

   assign mem_rdata = mem_read ? mem[mem_addr[7:0]] : 32'h0;

   always @(posedge clk) begin
      if (mem_write) mem[mem_addr[7:0]] <= mem_wdata;
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic set_a(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [5:0] op);
      req_a = 1'b1; we_a = we; addr_a = addr; wdata_a = wd; opcode_a = op;
   endtask

   task automatic set_b(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [5:0] op);
      req_b = 1'b1; we_b = we; addr_b = addr; wdata_b = wd; opcode_b = op;
   endtask

   // {gnt_a, gnt_b, done_a, done_b, err_a, err_b, mem_write, mem_read}
   function automatic logic [7:0] ctl();
      return {gnt_a, gnt_b, done_a, done_b, err_a, err_b, mem_write, mem_read};
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      reset = 1'b1;
      req_a = 0; req_b = 0; we_a = 0; we_b = 0;
      addr_a = 0; addr_b = 0; wdata_a = 0; wdata_b = 0; opcode_a = 0; opcode_b = 0;
      tick(2);
      reset = 1'b0;
      check_eq("reset_ctl", ctl(), 8'h00);
      check_eq("reset_bus", {mem_addr, mem_wdata}, 64'h0);
      check_eq("reset_rdata", {rdata_a, rdata_b}, 64'h0);

      // A: sw 0xDEADBEEF -> word 5
      set_a(1'b1, 32'd5, 32'hDEADBEEF, 6'h2B);
      tick(1);
      check_eq("sw_a_access_ctl", ctl(), 8'b1000_0010);
      check_eq("sw_a_bus", {mem_addr, mem_wdata}, {32'd5, 32'hDEADBEEF});
      check_eq("sw_a_opcode", mem_opcode, 6'h2B);
      req_a = 1'b0;
      tick(1);
      check_eq("sw_a_resp_ctl", ctl(), 8'b0010_0000);
      check_eq("sw_a_resp_bus", {mem_addr, mem_wdata}, 64'h0);
      tick(1);

      // B: lw word 5
      set_b(1'b0, 32'd5, 32'h0, 6'h23);
      tick(1);
      check_eq("lw_b_access_ctl", ctl(), 8'b0100_0001);
      check_eq("lw_b_addr", mem_addr, 32'd5);
      req_b = 1'b0;
      tick(1);
      check_eq("lw_b_resp_ctl", ctl(), 8'b0001_0000);
      check_eq("lw_b_rdata", rdata_b, 32'hDEADBEEF);
      tick(1);
      check_eq("lw_b_rdata_hold", rdata_b, 32'hDEADBEEF);

      // Conflict after reset: A, then B three cycles later, then A again
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      check_eq("reset2_rdata_b", rdata_b, 32'h0);
      set_a(1'b1, 32'd10, 32'h1, 6'h2B);
      set_b(1'b1, 32'd11, 32'h2, 6'h2B);
      tick(1);
      check_eq("rr_first_a", {gnt_a, gnt_b}, 2'b10);
      check_eq("rr_first_addr", mem_addr, 32'd10);
      tick(2);
      check_eq("rr_gap", {gnt_a, gnt_b}, 2'b00);
      tick(1);
      check_eq("rr_second_b", {gnt_a, gnt_b}, 2'b01);
      check_eq("rr_second_addr", mem_addr, 32'd11);
      tick(3);
      check_eq("rr_third_a", {gnt_a, gnt_b}, 2'b10);
      req_a = 1'b0; req_b = 1'b0;
      tick(2);

      // A: lw word 255 (last valid address)
      set_a(1'b0, 32'd255, 32'h0, 6'h23);
      mem[255] = 32'hCAFE0123;
      tick(1);
      check_eq("lw_a_255_ctl", ctl(), 8'b1000_0001);
      req_a = 1'b0;
      tick(1);
      check_eq("lw_a_255_rdata", rdata_a, 32'hCAFE0123);
      tick(1);

      // A: lw word 256 is out of range
      set_a(1'b0, 32'd256, 32'h0, 6'h23);
      tick(1);
      check_eq("oor_a_access_ctl", ctl(), 8'b1000_0000);
      check_eq("oor_a_bus", mem_addr, 32'h0);
      req_a = 1'b0;
      tick(1);
      check_eq("oor_a_resp_ctl", ctl(), 8'b0010_1000);
      check_eq("oor_a_rdata", rdata_a, 32'h0);
      tick(1);

      // B: store with illegal opcode 0x2A
      set_b(1'b1, 32'd3, 32'h55, 6'h2A);
      tick(1);
      check_eq("badop_b_access_ctl", ctl(), 8'b0100_0000);
      req_b = 1'b0;
      tick(1);
      check_eq("badop_b_resp_ctl", ctl(), 8'b0001_0100);
      check_eq("badop_b_mem3", mem[3], 32'h0);
      tick(1);

      // Reset during ACCESS of a load abandons it
      set_a(1'b0, 32'd5, 32'h0, 6'h23);
      tick(1);
      check_eq("rst_mid_access", ctl(), 8'b1000_0001);
      req_a = 1'b0;
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      check_eq("rst_mid_ctl", ctl(), 8'h00);
      check_eq("rst_mid_rdata", {rdata_a, rdata_b}, 64'h0);
      tick(1);
      check_eq("rst_mid_no_done", {done_a, done_b}, 2'b00);

      // Later request completes normally (word 10 holds 1 from the conflict test)
      set_b(1'b0, 32'd10, 32'h0, 6'h23);
      tick(1);
      check_eq("post_rst_access", ctl(), 8'b0100_0001);
      req_b = 1'b0;
      tick(1);
      check_eq("post_rst_resp", ctl(), 8'b0001_0000);
      check_eq("post_rst_rdata", rdata_b, 32'h1);
      tick(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mips_dmem_arbiter.md
Name: mips_dmem_arbiter

Overview:
Shares the single-port MIPS data memory between two requesters: port A (CPU load/store stage) and port B (debug/loader port). Round-robin arbitration with a registered request/grant/done handshake. Drives the memory's address, data, opcode, write and read strobes, and returns read data to the winner. Rejects out-of-range addresses and illegal store opcodes without touching memory.

Parameters:
DEPTH, 256, number of 32-bit memory words; valid addresses are 0..DEPTH-1
ADDR_W, 32, requester/memory address width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
req_a / req_b  in  1  access request, held until gnt_x
we_a / we_b  in  1  1=store, 0=load
addr_a / addr_b  in  ADDR_W  word address
wdata_a / wdata_b  in  32  store data
opcode_a / opcode_b  in  6  MIPS opcode (0x28 sb, 0x29 sh, 0x2B sw)
gnt_a / gnt_b  out  1  one-cycle pulse: request accepted
done_a / done_b  out  1  one-cycle pulse: access complete
err_a / err_b  out  1  valid with done_x: request rejected
rdata_a / rdata_b  out  32  load data, valid with done_x
mem_addr  out  ADDR_W  memory address
mem_wdata  out  32  memory write data
mem_opcode  out  6  opcode forwarded to memory
mem_write  out  1  memory write strobe
mem_read  out  1  memory read strobe
mem_rdata  in  32  memory read data (combinational from memory)

Behaviour:
- All outputs are registered. Reset drives every output to 0, the state to IDLE, and last_winner to B, so A wins the first conflict.
- FSM states: IDLE -> ACCESS -> RESP -> IDLE. Throughput is one access per 3 cycles.
- IDLE, cycle N:
  - If any req_x is high, select the winner: the sole requester, or on conflict the port that is not last_winner.
  - Latch the winner's we/addr/wdata/opcode and update last_winner.
  - Move to ACCESS.
  - If no request, remain in IDLE.
- ACCESS, cycle N+1:
  - gnt_winner=1 for this cycle only.
  - If addr >= DEPTH, or (we=1 and opcode not in {0x28, 0x29, 0x2B}), mark error; no strobe is asserted.
  - Otherwise drive mem_addr, mem_wdata and mem_opcode, and assert exactly one of mem_write (we=1) or mem_read (we=0) for this cycle only.
  - A load samples mem_rdata at the end of ACCESS.
- RESP, cycle N+2:
  - done_winner=1.
  - err_winner is set per the ACCESS check.
  - rdata_winner = sampled data for a good load; 0 for stores and errors.
  - rdata holds until that port's next done.
- mem_* buses are 0 whenever the state is not ACCESS. mem_read and mem_write are never both high.
- Requesters hold req and their fields until gnt_x and may drop req afterwards. A req still high in RESP is treated as a new request in the next IDLE.
- A loser keeps req high and is served next; starvation is bounded at one access.
- Reset asserted mid-operation abandons the access: outputs are 0 after that edge, and no done is issued for the abandoned access. A write strobe already issued in the ACCESS cycle is not rolled back.
- Address comparison is unsigned, across the full ADDR_W.

Decomposition:
- Shared package mips_mem_pkg:
  - opcode constants OP_SB=6'h28, OP_SH=6'h29, OP_SW=6'h2B, OP_LW=6'h23
  - FSM state encoding (IDLE, ACCESS, RESP)
  - default DEPTH
- Sub-module mips_rr_arbiter2: 2-way round-robin selector holding last_winner, with inputs req_a, req_b, advance and output winner.

Test Plan:
- Reset, then req_a store addr=5, wdata=0xDEADBEEF, opcode=0x2B -> gnt_a at N+1 with mem_write=1, mem_addr=5; done_a at N+2 with err_a=0.
- req_b load addr=5, opcode=0x23 -> mem_read at N+1; done_b at N+2 with rdata_b=0xDEADBEEF.
- req_a and req_b asserted together after reset and held -> A served first (gnt_a), then B (gnt_b 3 cycles later), then A again.
- req_a load addr=256 (DEPTH=256) -> no mem strobe; done_a=1, err_a=1, rdata_a=0.
- req_b store opcode=0x2A, addr=3 -> no mem_write; done_b with err_b=1.
- Reset asserted in the ACCESS cycle of a load -> next cycle all outputs 0, no done_x; a later request completes normally.
